// File: rtl/modinv_helper_invert_precalc_if.sv
// Operand read bus, helper-buffer write bus and decision flags of the
// modular-inversion precalculation stage, bundled for port connection.
interface modinv_helper_invert_precalc_if #(
    parameter int ADDR_BITS = 4
);
    // Start / status handshake
    logic                 ena;
    logic                 rdy;

    // Operand buffer read side (shared address, 1-cycle read latency)
    logic [ADDR_BITS-1:0] r_addr;
    logic [ADDR_BITS-1:0] s_addr;
    logic [ADDR_BITS-1:0] u_addr;
    logic [ADDR_BITS-1:0] v_addr;
    logic [31:0]          r_din;
    logic [31:0]          s_din;
    logic [31:0]          u_din;
    logic [31:0]          v_din;

    // Full-width helper group write side
    logic [ADDR_BITS-1:0] r_dbl_addr;
    logic [ADDR_BITS-1:0] s_dbl_addr;
    logic [ADDR_BITS-1:0] r_plus_s_addr;
    logic                 r_dbl_wren;
    logic                 s_dbl_wren;
    logic                 r_plus_s_wren;
    logic [31:0]          r_dbl_dout;
    logic [31:0]          s_dbl_dout;
    logic [31:0]          r_plus_s_dout;

    // Half helper group write side
    logic [ADDR_BITS-1:0] u_half_addr;
    logic [ADDR_BITS-1:0] v_half_addr;
    logic [ADDR_BITS-1:0] u_minus_v_half_addr;
    logic [ADDR_BITS-1:0] v_minus_u_half_addr;
    logic                 u_half_wren;
    logic                 v_half_wren;
    logic                 u_minus_v_half_wren;
    logic                 v_minus_u_half_wren;
    logic [31:0]          u_half_dout;
    logic [31:0]          v_half_dout;
    logic [31:0]          u_minus_v_half_dout;
    logic [31:0]          v_minus_u_half_dout;

    // Decision flags of the last completed run
    logic                 u_gt_v;
    logic                 v_eq_1;
    logic                 u_is_even;
    logic                 v_is_even;

    // Precalculation engine side
    modport master (
        input  ena,
        input  r_din, s_din, u_din, v_din,
        output rdy,
        output r_addr, s_addr, u_addr, v_addr,
        output r_dbl_addr, s_dbl_addr, r_plus_s_addr,
        output r_dbl_wren, s_dbl_wren, r_plus_s_wren,
        output r_dbl_dout, s_dbl_dout, r_plus_s_dout,
        output u_half_addr, v_half_addr, u_minus_v_half_addr, v_minus_u_half_addr,
        output u_half_wren, v_half_wren, u_minus_v_half_wren, v_minus_u_half_wren,
        output u_half_dout, v_half_dout, u_minus_v_half_dout, v_minus_u_half_dout,
        output u_gt_v, v_eq_1, u_is_even, v_is_even
    );

    // Buffer / controller side
    modport slave (
        output ena,
        output r_din, s_din, u_din, v_din,
        input  rdy,
        input  r_addr, s_addr, u_addr, v_addr,
        input  r_dbl_addr, s_dbl_addr, r_plus_s_addr,
        input  r_dbl_wren, s_dbl_wren, r_plus_s_wren,
        input  r_dbl_dout, s_dbl_dout, r_plus_s_dout,
        input  u_half_addr, v_half_addr, u_minus_v_half_addr, v_minus_u_half_addr,
        input  u_half_wren, v_half_wren, u_minus_v_half_wren, v_minus_u_half_wren,
        input  u_half_dout, v_half_dout, u_minus_v_half_dout, v_minus_u_half_dout,
        input  u_gt_v, v_eq_1, u_is_even, v_is_even
    );
endinterface

// File: rtl/modinv_helper_invert_precalc.sv
// Word-serial precalculation for one iteration of the binary modular
// inversion loop. Streams r/s/u/v LSW first and writes doubled, summed,
// halved and halved-difference candidates plus the decision flags.
module modinv_helper_invert_precalc #(
    parameter int BUFFER_NUM_WORDS = 9,
    parameter int BUFFER_ADDR_BITS = 4
) (
    input  logic                            clk,
    input  logic                            rst,
    modinv_helper_invert_precalc_if.master  bus_io
);

    localparam int N  = BUFFER_NUM_WORDS;
    localparam int CW = $clog2(BUFFER_NUM_WORDS + 4);
    localparam int AW = BUFFER_ADDR_BITS;

    localparam logic [CW-1:0] CNT_ZERO  = CW'(0);
    localparam logic [CW-1:0] CNT_ONE   = CW'(1);
    localparam logic [CW-1:0] CNT_TWO   = CW'(2);
    localparam logic [CW-1:0] CNT_THREE = CW'(3);
    localparam logic [CW-1:0] CNT_N     = CW'(N);
    localparam logic [CW-1:0] CNT_N1    = CW'(N + 1);
    localparam logic [CW-1:0] CNT_N2    = CW'(N + 2);
    localparam logic [CW-1:0] CNT_LAST  = CW'(N + 3);
    localparam logic [AW-1:0] ADDR_ZERO = AW'(0);

    // 32-bit add with carry in; bit 32 is the carry out
    function automatic logic [32:0] add_word(input logic [31:0] a,
                                             input logic [31:0] b,
                                             input logic        cin);
        return {1'b0, a} + {1'b0, b} + {32'd0, cin};
    endfunction

    // 32-bit subtract with borrow in; bit 32 is the borrow out
    function automatic logic [32:0] sub_word(input logic [31:0] a,
                                             input logic [31:0] b,
                                             input logic        bin);
        return {1'b0, a} - {1'b0, b} - {32'd0, bin};
    endfunction

    // Sequencer and status
    logic [CW-1:0] cnt_q, cnt_d;
    logic          rdy_q, rdy_d;
    logic [AW-1:0] rd_addr_q, rd_addr_d;

    // Full-width group
    logic          full_wren_q, full_wren_d;
    logic [AW-1:0] full_addr_q, full_addr_d;
    logic [31:0]   r_dbl_q, r_dbl_d;
    logic [31:0]   s_dbl_q, s_dbl_d;
    logic [31:0]   r_plus_s_q, r_plus_s_d;
    logic          r_msb_q, r_msb_d;
    logic          s_msb_q, s_msb_d;
    logic          add_c_q, add_c_d;

    // Half group
    logic          half_wren_q, half_wren_d;
    logic [AW-1:0] half_addr_q, half_addr_d;
    logic [31:0]   u_half_q, u_half_d;
    logic [31:0]   v_half_q, v_half_d;
    logic [31:0]   umv_half_q, umv_half_d;
    logic [31:0]   vmu_half_q, vmu_half_d;
    logic          bd_q, bd_d;
    logic          be_q, be_d;
    logic [31:0]   u_prev_q, u_prev_d;
    logic [31:0]   v_prev_q, v_prev_d;
    logic [31:0]   d_prev_q, d_prev_d;
    logic [31:0]   e_prev_q, e_prev_d;

    // Flag accumulators and committed flags
    logic          acc_u_even_q, acc_u_even_d;
    logic          acc_v_even_q, acc_v_even_d;
    logic          acc_v_eq1_q, acc_v_eq1_d;
    logic          flag_u_gt_v_q, flag_u_gt_v_d;
    logic          flag_v_eq_1_q, flag_v_eq_1_d;
    logic          flag_u_even_q, flag_u_even_d;
    logic          flag_v_even_q, flag_v_even_d;

    // Combinational helpers
    logic          word_vld_s;
    logic          first_word_s;
    logic          half_calc_s;
    logic          half_last_s;
    logic          r_cin_s;
    logic          s_cin_s;
    logic          add_cin_s;
    logic          bd_in_s;
    logic          be_in_s;
    logic [32:0]   sum_s;
    logic [32:0]   d_s;
    logic [32:0]   e_s;
    logic          fill_u_s;
    logic          fill_v_s;
    logic          fill_d_s;
    logic          fill_e_s;

    // Next-state computation for sequencer, datapath and flags
    always_comb begin
        // hold everything by default
        cnt_d         = cnt_q;
        rdy_d         = rdy_q;
        rd_addr_d     = rd_addr_q;
        full_wren_d   = full_wren_q;
        full_addr_d   = full_addr_q;
        r_dbl_d       = r_dbl_q;
        s_dbl_d       = s_dbl_q;
        r_plus_s_d    = r_plus_s_q;
        r_msb_d       = r_msb_q;
        s_msb_d       = s_msb_q;
        add_c_d       = add_c_q;
        half_wren_d   = half_wren_q;
        half_addr_d   = half_addr_q;
        u_half_d      = u_half_q;
        v_half_d      = v_half_q;
        umv_half_d    = umv_half_q;
        vmu_half_d    = vmu_half_q;
        bd_d          = bd_q;
        be_d          = be_q;
        u_prev_d      = u_prev_q;
        v_prev_d      = v_prev_q;
        d_prev_d      = d_prev_q;
        e_prev_d      = e_prev_q;
        acc_u_even_d  = acc_u_even_q;
        acc_v_even_d  = acc_v_even_q;
        acc_v_eq1_d   = acc_v_eq1_q;
        flag_u_gt_v_d = flag_u_gt_v_q;
        flag_v_eq_1_d = flag_v_eq_1_q;
        flag_u_even_d = flag_u_even_q;
        flag_v_even_d = flag_v_even_q;

        // run sequencer: idle at 0, free-running through N+3 once started
        if (cnt_q == CNT_ZERO) begin
            if (bus_io.ena) begin
                cnt_d = CNT_ONE;
            end else begin
                cnt_d = CNT_ZERO;
            end
        end else if (cnt_q == CNT_LAST) begin
            cnt_d = CNT_ZERO;
        end else begin
            cnt_d = cnt_q + CNT_ONE;
        end
        rdy_d = (cnt_d == CNT_ZERO);

        // read address tracks the counter value it will coexist with
        if ((cnt_d >= CNT_ONE) && (cnt_d <= CNT_N)) begin
            rd_addr_d = AW'(cnt_d - CNT_ONE);
        end else begin
            rd_addr_d = ADDR_ZERO;
        end

        // word j of read data is on the bus while cnt = j+2
        word_vld_s   = (cnt_q >= CNT_TWO) && (cnt_q <= CNT_N1);
        first_word_s = (cnt_q == CNT_TWO);
        // half word k is formed once word k+1 arrives (or as the top word)
        half_calc_s  = (cnt_q >= CNT_THREE) && (cnt_q <= CNT_N2);
        half_last_s  = (cnt_q == CNT_N2);

        // carries and borrows restart at the least significant word
        r_cin_s   = first_word_s ? 1'b0 : r_msb_q;
        s_cin_s   = first_word_s ? 1'b0 : s_msb_q;
        add_cin_s = first_word_s ? 1'b0 : add_c_q;
        bd_in_s   = first_word_s ? 1'b0 : bd_q;
        be_in_s   = first_word_s ? 1'b0 : be_q;

        sum_s = add_word(bus_io.r_din, bus_io.s_din, add_cin_s);
        d_s   = sub_word(bus_io.u_din, bus_io.v_din, bd_in_s);
        e_s   = sub_word(bus_io.v_din, bus_io.u_din, be_in_s);

        // top word of every halved result shifts in zero
        if (half_last_s) begin
            fill_u_s = 1'b0;
            fill_v_s = 1'b0;
            fill_d_s = 1'b0;
            fill_e_s = 1'b0;
        end else begin
            fill_u_s = bus_io.u_din[0];
            fill_v_s = bus_io.v_din[0];
            fill_d_s = d_s[0];
            fill_e_s = e_s[0];
        end

        // full-width group and raw-word pipeline
        if (word_vld_s) begin
            full_wren_d = 1'b1;
            full_addr_d = AW'(cnt_q - CNT_TWO);
            r_dbl_d     = {bus_io.r_din[30:0], r_cin_s};
            s_dbl_d     = {bus_io.s_din[30:0], s_cin_s};
            r_plus_s_d  = sum_s[31:0];
            r_msb_d     = bus_io.r_din[31];
            s_msb_d     = bus_io.s_din[31];
            add_c_d     = sum_s[32];
            bd_d        = d_s[32];
            be_d        = e_s[32];
            u_prev_d    = bus_io.u_din;
            v_prev_d    = bus_io.v_din;
            d_prev_d    = d_s[31:0];
            e_prev_d    = e_s[31:0];
        end else begin
            full_wren_d = 1'b0;
            full_addr_d = ADDR_ZERO;
        end

        // parity and v==1 accumulation
        if (word_vld_s && first_word_s) begin
            acc_u_even_d = ~bus_io.u_din[0];
            acc_v_even_d = ~bus_io.v_din[0];
            acc_v_eq1_d  = (bus_io.v_din == 32'd1);
        end else if (word_vld_s) begin
            acc_v_eq1_d  = acc_v_eq1_q & (bus_io.v_din == 32'd0);
        end else begin
            acc_v_eq1_d  = acc_v_eq1_q;
        end

        // half group: combine held word with LSB of the next word
        if (half_calc_s) begin
            half_wren_d = 1'b1;
            half_addr_d = AW'(cnt_q - CNT_THREE);
            u_half_d    = {fill_u_s, u_prev_q[31:1]};
            v_half_d    = {fill_v_s, v_prev_q[31:1]};
            umv_half_d  = {fill_d_s, d_prev_q[31:1]};
            vmu_half_d  = {fill_e_s, e_prev_q[31:1]};
        end else begin
            half_wren_d = 1'b0;
            half_addr_d = ADDR_ZERO;
        end

        // commit flags on the edge that ends the run
        if (cnt_q == CNT_LAST) begin
            flag_u_gt_v_d = be_q;
            flag_v_eq_1_d = acc_v_eq1_q;
            flag_u_even_d = acc_u_even_q;
            flag_v_even_d = acc_v_even_q;
        end else begin
            flag_u_gt_v_d = flag_u_gt_v_q;
            flag_v_eq_1_d = flag_v_eq_1_q;
            flag_u_even_d = flag_u_even_q;
            flag_v_even_d = flag_v_even_q;
        end
    end

    // State registers with synchronous reset
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q         <= CNT_ZERO;
            rdy_q         <= 1'b1;
            rd_addr_q     <= ADDR_ZERO;
            full_wren_q   <= 1'b0;
            full_addr_q   <= ADDR_ZERO;
            r_dbl_q       <= 32'd0;
            s_dbl_q       <= 32'd0;
            r_plus_s_q    <= 32'd0;
            r_msb_q       <= 1'b0;
            s_msb_q       <= 1'b0;
            add_c_q       <= 1'b0;
            half_wren_q   <= 1'b0;
            half_addr_q   <= ADDR_ZERO;
            u_half_q      <= 32'd0;
            v_half_q      <= 32'd0;
            umv_half_q    <= 32'd0;
            vmu_half_q    <= 32'd0;
            bd_q          <= 1'b0;
            be_q          <= 1'b0;
            u_prev_q      <= 32'd0;
            v_prev_q      <= 32'd0;
            d_prev_q      <= 32'd0;
            e_prev_q      <= 32'd0;
            acc_u_even_q  <= 1'b0;
            acc_v_even_q  <= 1'b0;
            acc_v_eq1_q   <= 1'b0;
            flag_u_gt_v_q <= 1'b0;
            flag_v_eq_1_q <= 1'b0;
            flag_u_even_q <= 1'b0;
            flag_v_even_q <= 1'b0;
        end else begin
            cnt_q         <= cnt_d;
            rdy_q         <= rdy_d;
            rd_addr_q     <= rd_addr_d;
            full_wren_q   <= full_wren_d;
            full_addr_q   <= full_addr_d;
            r_dbl_q       <= r_dbl_d;
            s_dbl_q       <= s_dbl_d;
            r_plus_s_q    <= r_plus_s_d;
            r_msb_q       <= r_msb_d;
            s_msb_q       <= s_msb_d;
            add_c_q       <= add_c_d;
            half_wren_q   <= half_wren_d;
            half_addr_q   <= half_addr_d;
            u_half_q      <= u_half_d;
            v_half_q      <= v_half_d;
            umv_half_q    <= umv_half_d;
            vmu_half_q    <= vmu_half_d;
            bd_q          <= bd_d;
            be_q          <= be_d;
            u_prev_q      <= u_prev_d;
            v_prev_q      <= v_prev_d;
            d_prev_q      <= d_prev_d;
            e_prev_q      <= e_prev_d;
            acc_u_even_q  <= acc_u_even_d;
            acc_v_even_q  <= acc_v_even_d;
            acc_v_eq1_q   <= acc_v_eq1_d;
            flag_u_gt_v_q <= flag_u_gt_v_d;
            flag_v_eq_1_q <= flag_v_eq_1_d;
            flag_u_even_q <= flag_u_even_d;
            flag_v_even_q <= flag_v_even_d;
        end
    end

    assign bus_io.rdy                 = rdy_q;
    assign bus_io.r_addr              = rd_addr_q;
    assign bus_io.s_addr              = rd_addr_q;
    assign bus_io.u_addr              = rd_addr_q;
    assign bus_io.v_addr              = rd_addr_q;

    assign bus_io.r_dbl_addr          = full_addr_q;
    assign bus_io.s_dbl_addr          = full_addr_q;
    assign bus_io.r_plus_s_addr       = full_addr_q;
    assign bus_io.r_dbl_wren          = full_wren_q;
    assign bus_io.s_dbl_wren          = full_wren_q;
    assign bus_io.r_plus_s_wren       = full_wren_q;
    assign bus_io.r_dbl_dout          = r_dbl_q;
    assign bus_io.s_dbl_dout          = s_dbl_q;
    assign bus_io.r_plus_s_dout       = r_plus_s_q;

    assign bus_io.u_half_addr         = half_addr_q;
    assign bus_io.v_half_addr         = half_addr_q;
    assign bus_io.u_minus_v_half_addr = half_addr_q;
    assign bus_io.v_minus_u_half_addr = half_addr_q;
    assign bus_io.u_half_wren         = half_wren_q;
    assign bus_io.v_half_wren         = half_wren_q;
    assign bus_io.u_minus_v_half_wren = half_wren_q;
    assign bus_io.v_minus_u_half_wren = half_wren_q;
    assign bus_io.u_half_dout         = u_half_q;
    assign bus_io.v_half_dout         = v_half_q;
    assign bus_io.u_minus_v_half_dout = umv_half_q;
    assign bus_io.v_minus_u_half_dout = vmu_half_q;

    assign bus_io.u_gt_v              = flag_u_gt_v_q;
    assign bus_io.v_eq_1              = flag_v_eq_1_q;
    assign bus_io.u_is_even           = flag_u_even_q;
    assign bus_io.v_is_even           = flag_v_even_q;

endmodule

// File: tb/tb_modinv_helper_invert_precalc.sv
// Scoreboard bench for modinv_helper_invert_precalc: expected helper words
// and flags come from a wide-integer model when a run is accepted, and are
// popped and compared as the DUT writes them.
module tb_modinv_helper_invert_precalc;

    localparam int N    = 9;
    localparam int AB   = 4;
    localparam int W    = N * 32;
    localparam int LAST = N + 3;

    logic clk = 1'b0;
    logic rst;

    // 100 MHz clock
    always #5 clk = ~clk;

    modinv_helper_invert_precalc_if #(.ADDR_BITS(AB)) bus ();

    modinv_helper_invert_precalc #(
        .BUFFER_NUM_WORDS(N),
        .BUFFER_ADDR_BITS(AB)
    ) dut (
        .clk    (clk),
        .rst    (rst),
        .bus_io (bus)
    );

    logic [31:0] r_mem [16];
    logic [31:0] s_mem [16];
    logic [31:0] u_mem [16];
    logic [31:0] v_mem [16];

    logic [31:0] q_rdbl [$];
    logic [31:0] q_sdbl [$];
    logic [31:0] q_rps  [$];
    logic [31:0] q_uh   [$];
    logic [31:0] q_vh   [$];
    logic [31:0] q_umv  [$];
    logic [31:0] q_vmu  [$];
    logic [3:0]  q_flags[$];

    int n_checks = 0;
    int n_pass   = 0;
    int tb_cnt   = 0;
    bit done_q   = 1'b0;

    // single comparison point
    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        if (obs === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", tag, obs, exp);
    endtask

    // reference model on full-width integers
    task automatic push_expected();
        logic [W-1:0] rv, sv, uv, vv, rd, rps, uh, vh, dm, em;
        for (int j = 0; j < N; j++) begin
            rv[j*32 +: 32] = r_mem[j];
            sv[j*32 +: 32] = s_mem[j];
            uv[j*32 +: 32] = u_mem[j];
            vv[j*32 +: 32] = v_mem[j];
        end
        rd  = rv << 1;
        rps = rv + sv;
        uh  = uv >> 1;
        vh  = vv >> 1;
        dm  = uv - vv;
        dm  = dm >> 1;
        em  = vv - uv;
        em  = em >> 1;
        for (int j = 0; j < N; j++) begin
            q_rdbl.push_back(rd[j*32 +: 32]);
            q_sdbl.push_back({sv[j*32 +: 31], (j == 0) ? 1'b0 : sv[j*32-1]});
            q_rps.push_back(rps[j*32 +: 32]);
            q_uh.push_back(uh[j*32 +: 32]);
            q_vh.push_back(vh[j*32 +: 32]);
            q_umv.push_back(dm[j*32 +: 32]);
            q_vmu.push_back(em[j*32 +: 32]);
        end
        q_flags.push_back({uv > vv, vv == W'(1), ~uv[0], ~vv[0]});
    endtask

    // operand buffers with one cycle of read latency
    always @(posedge clk) begin
        bus.r_din <= r_mem[bus.r_addr];
        bus.s_din <= s_mem[bus.s_addr];
        bus.u_din <= u_mem[bus.u_addr];
        bus.v_din <= v_mem[bus.v_addr];
    end

    // control model and scoreboard push on accepted starts
    always @(posedge clk) begin
        done_q <= 1'b0;
        if (rst) begin
            tb_cnt <= 0;
            q_rdbl.delete(); q_sdbl.delete(); q_rps.delete(); q_uh.delete();
            q_vh.delete(); q_umv.delete(); q_vmu.delete(); q_flags.delete();
        end else if (tb_cnt == 0) begin
            if (bus.ena) begin
                tb_cnt <= 1;
                push_expected();
            end
        end else if (tb_cnt == LAST) begin
            tb_cnt <= 0;
            done_q <= 1'b1;
        end else begin
            tb_cnt <= tb_cnt + 1;
        end
    end

    // output monitor on the falling edge
    always @(negedge clk) begin : mon
        logic fw, hw;
        logic [AB-1:0] ra, fa, ha;
        logic [31:0] e;
        fw = (tb_cnt >= 3) && (tb_cnt <= N + 2);
        hw = (tb_cnt >= 4) && (tb_cnt <= N + 3);
        ra = ((tb_cnt >= 1) && (tb_cnt <= N)) ? AB'(tb_cnt - 1) : AB'(0);
        fa = fw ? AB'(tb_cnt - 3) : AB'(0);
        ha = hw ? AB'(tb_cnt - 4) : AB'(0);
        chk("rdy", 64'(bus.rdy), 64'(tb_cnt == 0));
        chk("wren", 64'({bus.r_dbl_wren, bus.s_dbl_wren, bus.r_plus_s_wren, bus.u_half_wren,
                         bus.v_half_wren, bus.u_minus_v_half_wren, bus.v_minus_u_half_wren}),
                    64'({fw, fw, fw, hw, hw, hw, hw}));
        chk("addr", 64'({bus.r_addr, bus.s_addr, bus.u_addr, bus.v_addr,
                         bus.r_dbl_addr, bus.s_dbl_addr, bus.r_plus_s_addr,
                         bus.u_half_addr, bus.v_half_addr,
                         bus.u_minus_v_half_addr, bus.v_minus_u_half_addr}),
                    64'({ra, ra, ra, ra, fa, fa, fa, ha, ha, ha, ha}));
        if (fw) begin
            e = 'x; if (q_rdbl.size() > 0) e = q_rdbl.pop_front();
            chk("r_dbl", 64'(bus.r_dbl_dout), {32'd0, e});
            e = 'x; if (q_sdbl.size() > 0) e = q_sdbl.pop_front();
            chk("s_dbl", 64'(bus.s_dbl_dout), {32'd0, e});
            e = 'x; if (q_rps.size() > 0) e = q_rps.pop_front();
            chk("r_plus_s", 64'(bus.r_plus_s_dout), {32'd0, e});
        end
        if (hw) begin
            e = 'x; if (q_uh.size() > 0) e = q_uh.pop_front();
            chk("u_half", 64'(bus.u_half_dout), {32'd0, e});
            e = 'x; if (q_vh.size() > 0) e = q_vh.pop_front();
            chk("v_half", 64'(bus.v_half_dout), {32'd0, e});
            e = 'x; if (q_umv.size() > 0) e = q_umv.pop_front();
            chk("u_minus_v_half", 64'(bus.u_minus_v_half_dout), {32'd0, e});
            e = 'x; if (q_vmu.size() > 0) e = q_vmu.pop_front();
            chk("v_minus_u_half", 64'(bus.v_minus_u_half_dout), {32'd0, e});
        end
        if (done_q) begin
            logic [3:0] f;
            f = 'x; if (q_flags.size() > 0) f = q_flags.pop_front();
            chk("flags", 64'({bus.u_gt_v, bus.v_eq_1, bus.u_is_even, bus.v_is_even}), {60'd0, f});
        end
    end

    task automatic set_ops(input logic [W-1:0] r, input logic [W-1:0] s,
                           input logic [W-1:0] u, input logic [W-1:0] v);
        for (int j = 0; j < N; j++) begin
            r_mem[j] = r[j*32 +: 32];
            s_mem[j] = s[j*32 +: 32];
            u_mem[j] = u[j*32 +: 32];
            v_mem[j] = v[j*32 +: 32];
        end
    endtask

    function automatic logic [W-1:0] rnd_big();
        logic [W-1:0] x;
        for (int j = 0; j < N; j++) x[j*32 +: 32] = $urandom;
        return x;
    endfunction

    // pulse ena for one cycle, then wait (bounded) for rdy and check run length
    task automatic run_one();
        int lowcnt;
        bus.ena = 1'b1;
        @(posedge clk); #1;
        bus.ena = 1'b0;
        lowcnt = 0;
        for (int i = 0; i < 40; i++) begin
            if (bus.rdy) break;
            lowcnt++;
            @(posedge clk); #1;
        end
        chk("rdy_return", 64'(bus.rdy), 64'd1);
        chk("rdy_low_cycles", 64'(lowcnt), 64'(N + 3));
    endtask

    initial begin
        rst     = 1'b1;
        bus.ena = 1'b0;
        for (int j = 0; j < 16; j++) begin
            r_mem[j] = 32'd0; s_mem[j] = 32'd0; u_mem[j] = 32'd0; v_mem[j] = 32'd0;
        end
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        chk("reset_flags", 64'({bus.u_gt_v, bus.v_eq_1, bus.u_is_even, bus.v_is_even}), 64'd0);
        chk("reset_rdy", 64'(bus.rdy), 64'd1);

        // basic odd operands
        set_ops(W'(1), W'(0), W'(7), W'(3));
        run_one();
        // v == 1, even u
        set_ops(W'(5), W'(2), W'(4), W'(1));
        run_one();
        // carries and borrows across words
        set_ops(W'(64'h80000000_FFFFFFFF), W'(64'h80000000_FFFFFFFF),
                W'(64'h1_00000000), W'(1));
        run_one();
        // equal u and v, then back-to-back run on the rdy-rise cycle
        set_ops(W'(3), W'(9), W'(5), W'(5));
        run_one();
        set_ops(rnd_big(), rnd_big(), W'(9), W'(2));
        run_one();

        // reset in the middle of a run
        set_ops(rnd_big(), rnd_big(), rnd_big(), rnd_big());
        bus.ena = 1'b1;
        @(posedge clk); #1;
        bus.ena = 1'b0;
        repeat (4) @(posedge clk);
        #1 rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        chk("abort_rdy", 64'(bus.rdy), 64'd1);
        chk("abort_flags", 64'({bus.u_gt_v, bus.v_eq_1, bus.u_is_even, bus.v_is_even}), 64'd0);
        run_one();

        // random operands
        for (int t = 0; t < 3; t++) begin
            set_ops(rnd_big(), rnd_big(), rnd_big(), rnd_big());
            run_one();
        end

        // ena held high: consecutive runs
        set_ops(rnd_big(), rnd_big(), rnd_big(), rnd_big());
        bus.ena = 1'b1;
        repeat (30) @(posedge clk);
        #1 bus.ena = 1'b0;
        for (int i = 0; i < 30; i++) begin
            if (bus.rdy) break;
            @(posedge clk); #1;
        end
        chk("cont_rdy_return", 64'(bus.rdy), 64'd1);
        repeat (2) @(posedge clk);
        #1;
        chk("queues_drained", 64'(q_rdbl.size() + q_sdbl.size() + q_rps.size() + q_uh.size()
                                  + q_vh.size() + q_umv.size() + q_vmu.size() + q_flags.size()),
            64'd0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
